// File: rtl/pick_game_ctrl.sv
// Pick game controller: screen state machine, per-frame pick movement with
// clamping, and hit/miss/timeout judging feeding the colour mapper.
module pick_game_ctrl #(
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 639,
  parameter int unsigned Y_MIN        = 0,
  parameter int unsigned Y_MAX        = 479,
  parameter int unsigned STEP         = 2,
  parameter int unsigned X_START      = 320,
  parameter int unsigned Y_START      = 240,
  parameter int unsigned L1_TX        = 100,
  parameter int unsigned L1_TY        = 200,
  parameter int unsigned L2_TX        = 500,
  parameter int unsigned L2_TY        = 120,
  parameter int unsigned TGT_HALF     = 8,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned LEVEL_FRAMES = 1800
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  output logic [9:0]  PickX,
  output logic [9:0]  PickY,
  output logic [2:0]  currScreen,
  output logic [2:0]  tries_left,
  output logic [10:0] frame_cnt
);

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam logic signed [10:0] STEP_S = $signed(11'(STEP));
  localparam logic signed [10:0] XMIN_S = $signed(11'(X_MIN));
  localparam logic signed [10:0] XMAX_S = $signed(11'(X_MAX));
  localparam logic signed [10:0] YMIN_S = $signed(11'(Y_MIN));
  localparam logic signed [10:0] YMAX_S = $signed(11'(Y_MAX));
  localparam logic [9:0]  X_ST     = 10'(X_START);
  localparam logic [9:0]  Y_ST     = 10'(Y_START);
  localparam logic [10:0] HALF     = 11'(TGT_HALF);
  localparam logic [2:0]  TRIES    = 3'(MAX_TRIES);
  localparam logic [10:0] CNT_LAST = 11'(LEVEL_FRAMES - 1);

  typedef enum logic [2:0] {
    S_TITLE  = 3'b000,
    S_LEVEL1 = 3'b001,
    S_LEVEL2 = 3'b010,
    S_WIN    = 3'b111,
    S_FAIL   = 3'b100
  } screen_t;

  screen_t     screen, screen_nxt;
  logic        stage1, stage2, tick;
  logic [7:0]  key_prev;
  logic        press_enter, press_space, hit, timeout;
  logic [9:0]  pick_x_nxt, pick_y_nxt, move_x, move_y;
  logic [2:0]  tries_nxt, tries_dec;
  logic [10:0] cnt_nxt, cnt_inc;
  logic signed [10:0] mx, my;
  logic [10:0] px, py, tx, ty;

  // frame_clk is asynchronous data: two-stage capture, rising-edge tick
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stage1     <= 1'b0;
      stage2     <= 1'b0;
      key_prev   <= 8'h00;
      screen     <= S_TITLE;
      PickX      <= X_ST;
      PickY      <= Y_ST;
      tries_left <= TRIES;
      frame_cnt  <= 11'd0;
    end else begin
      stage1     <= frame_clk;
      stage2     <= stage1;
      if (tick) key_prev <= keycode;
      screen     <= screen_nxt;
      PickX      <= pick_x_nxt;
      PickY      <= pick_y_nxt;
      tries_left <= tries_nxt;
      frame_cnt  <= cnt_nxt;
    end
  end

  assign tick        = stage1 & ~stage2;
  assign currScreen  = screen;
  assign press_enter = (keycode == KEY_ENTER) && (key_prev != KEY_ENTER);
  assign press_space = (keycode == KEY_SPACE) && (key_prev != KEY_SPACE);
  assign cnt_inc     = (frame_cnt >= CNT_LAST) ? frame_cnt : frame_cnt + 11'd1;
  assign timeout     = (cnt_inc == CNT_LAST);
  assign tries_dec   = (tries_left == 3'd0) ? 3'd0 : tries_left - 3'd1;

  // Held-key movement in signed 11 bits, clamped to the pick window
  always_comb begin
    mx = $signed({1'b0, PickX});
    my = $signed({1'b0, PickY});
    case (keycode)
      KEY_A:   mx = mx - STEP_S;
      KEY_D:   mx = mx + STEP_S;
      KEY_W:   my = my - STEP_S;
      KEY_S:   my = my + STEP_S;
      default: ;
    endcase
    move_x = (mx < XMIN_S) ? XMIN_S[9:0] : (mx > XMAX_S) ? XMAX_S[9:0] : mx[9:0];
    move_y = (my < YMIN_S) ? YMIN_S[9:0] : (my > YMAX_S) ? YMAX_S[9:0] : my[9:0];
  end

  // Hit window judged on the pre-movement pick position
  always_comb begin
    px  = {1'b0, PickX};
    py  = {1'b0, PickY};
    tx  = (screen == S_LEVEL2) ? 11'(L2_TX) : 11'(L1_TX);
    ty  = (screen == S_LEVEL2) ? 11'(L2_TY) : 11'(L1_TY);
    hit = (px + HALF >= tx) && (px <= tx + HALF) &&
          (py + HALF >= ty) && (py <= ty + HALF);
  end

  always_comb begin
    screen_nxt = screen;
    pick_x_nxt = PickX;
    pick_y_nxt = PickY;
    tries_nxt  = tries_left;
    cnt_nxt    = frame_cnt;
    if (tick) begin
      case (screen)
        S_TITLE: begin
          pick_x_nxt = X_ST;
          pick_y_nxt = Y_ST;
          if (press_enter) begin
            screen_nxt = S_LEVEL1;
            tries_nxt  = TRIES;
            cnt_nxt    = 11'd0;
          end
        end
        S_LEVEL1, S_LEVEL2: begin
          cnt_nxt    = cnt_inc;
          pick_x_nxt = move_x;
          pick_y_nxt = move_y;
          if (press_space && hit) begin
            pick_x_nxt = X_ST;
            pick_y_nxt = Y_ST;
            if (screen == S_LEVEL1) begin
              screen_nxt = S_LEVEL2;
              tries_nxt  = TRIES;
              cnt_nxt    = 11'd0;
            end else begin
              screen_nxt = S_WIN;
            end
          end else begin
            if (press_space) tries_nxt = tries_dec;
            if ((press_space && tries_dec == 3'd0) || timeout) begin
              screen_nxt = S_FAIL;
              pick_x_nxt = X_ST;
              pick_y_nxt = Y_ST;
            end
          end
        end
        S_WIN, S_FAIL: begin
          pick_x_nxt = X_ST;
          pick_y_nxt = Y_ST;
          if (press_enter) begin
            screen_nxt = S_TITLE;
            tries_nxt  = TRIES;
            cnt_nxt    = 11'd0;
          end
        end
        default: begin
          screen_nxt = S_TITLE;
          pick_x_nxt = X_ST;
          pick_y_nxt = Y_ST;
          tries_nxt  = TRIES;
          cnt_nxt    = 11'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pick_game_ctrl.sv
// Scoreboarded bench for pick_game_ctrl: directed game scenarios plus random
// key streams, checked against a frame-level behavioural model of the game.
module tb_pick_game_ctrl;

  localparam logic [7:0] K_W = 8'h1A, K_S = 8'h16, K_A = 8'h04, K_D = 8'h07;
  localparam logic [7:0] K_ENTER = 8'h28, K_SPACE = 8'h2C, K_NONE = 8'h00;

  logic        Clk, Reset, frame_clk;
  logic [7:0]  keycode;
  logic [9:0]  PickX, PickY;
  logic [2:0]  currScreen, tries_left;
  logic [10:0] frame_cnt;

  pick_game_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .PickX(PickX), .PickY(PickY), .currScreen(currScreen),
    .tries_left(tries_left), .frame_cnt(frame_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int scr; int x; int y; int tries; int cnt; int id;
  } snap_t;

  snap_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;

  // Game model: one call per frame, screens as their output codes
  int m_scr, m_x, m_y, m_tries, m_cnt;
  logic [7:0] m_prev;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_scr = 0; m_x = 320; m_y = 240; m_tries = 3; m_cnt = 0; m_prev = 8'h00;
  endtask

  task automatic model_frame(input logic [7:0] k);
    bit pe, ps, hit;
    int tx, ty, nx, ny;
    pe = (k == K_ENTER) && (m_prev != K_ENTER);
    ps = (k == K_SPACE) && (m_prev != K_SPACE);
    if (m_scr == 1 || m_scr == 2) begin
      tx = (m_scr == 1) ? 100 : 500;
      ty = (m_scr == 1) ? 200 : 120;
      hit = absi(m_x - tx) <= 8 && absi(m_y - ty) <= 8;
      m_cnt = (m_cnt + 1 > 1799) ? 1799 : m_cnt + 1;
      nx = m_x; ny = m_y;
      if (k == K_A) nx = m_x - 2;
      if (k == K_D) nx = m_x + 2;
      if (k == K_W) ny = m_y - 2;
      if (k == K_S) ny = m_y + 2;
      if (ps && hit) begin
        m_x = 320; m_y = 240;
        if (m_scr == 1) begin m_scr = 2; m_tries = 3; m_cnt = 0; end
        else m_scr = 7;
      end else begin
        m_x = clampi(nx, 0, 639);
        m_y = clampi(ny, 0, 479);
        if (ps && m_tries > 0) m_tries = m_tries - 1;
        if ((ps && m_tries == 0) || m_cnt == 1799) begin
          m_scr = 4; m_x = 320; m_y = 240;
        end
      end
    end else begin
      m_x = 320; m_y = 240;
      if (pe) begin
        m_scr = (m_scr == 0) ? 1 : 0;
        m_tries = 3; m_cnt = 0;
      end
    end
    m_prev = k;
  endtask

  task automatic push_exp();
    snap_t s;
    s.scr = m_scr; s.x = m_x; s.y = m_y; s.tries = m_tries; s.cnt = m_cnt;
    s.id = n_push;
    n_push++;
    exp_q.push_back(s);
  endtask

  task automatic check(input string name, input int id, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s (snapshot %0d): got %0d, required %0d", name, id, act, req);
    end
  endtask

  // Monitor: DUT outputs are stable whenever a snapshot is queued
  initial begin
    snap_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("currScreen", e.id, int'(currScreen), e.scr);
        check("PickX",      e.id, int'(PickX),      e.x);
        check("PickY",      e.id, int'(PickY),      e.y);
        check("tries_left", e.id, int'(tries_left), e.tries);
        check("frame_cnt",  e.id, int'(frame_cnt),  e.cnt);
      end
    end
  end

  // One frame_clk pulse with key k held; called and returns at a negedge
  task automatic frame(input logic [7:0] k);
    keycode   = k;
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    model_frame(k);
    push_exp();
    @(negedge Clk);
  endtask

  task automatic hold(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) frame(k);
  endtask

  // Reset raised between edges; checked before the next rising edge
  task automatic async_reset();
    @(posedge Clk);
    #2 Reset = 1'b1;
    model_reset();
    push_exp();
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic gate_hold();
    logic [7:0] keys [4];
    keys[0] = K_D; keys[1] = K_ENTER; keys[2] = K_SPACE; keys[3] = K_W;
    for (int i = 0; i < 10; i++) begin
      keycode = keys[i % 4];
      repeat (100) @(negedge Clk);
      push_exp();
    end
    @(negedge Clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d snapshots pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] k;
    int len;
    Reset = 1'b1; frame_clk = 1'b0; keycode = K_NONE;
    model_reset();
    repeat (2) @(negedge Clk);
    push_exp();
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    hold(K_ENTER, 3);                       // title -> level 1, no re-trigger
    hold(K_D, 160); hold(K_A, 318);         // reach odd X=3
    hold(K_A, 3);                           // 1, 0, 0
    hold(K_D, 320); hold(K_A, 1);           // 639 then 637
    hold(K_D, 2);                           // 639, 639
    hold(K_A, 320); hold(K_D, 54); hold(K_W, 20);
    frame(K_SPACE);                         // hit at (108,200) -> level 2
    hold(K_D, 90); hold(K_W, 60);           // level 2 target (500,120)
    gate_hold();
    frame(K_SPACE);                         // -> win
    frame(K_ENTER);                         // -> title
    frame(K_NONE); frame(K_ENTER);
    hold(K_D, 160); hold(K_A, 265); hold(K_W, 20);
    frame(K_SPACE); frame(K_NONE);          // (109,200) misses
    frame(K_SPACE); frame(K_NONE);
    frame(K_SPACE);                         // tries exhausted -> fail
    frame(K_ENTER); frame(K_NONE); frame(K_ENTER);
    hold(K_A, 106); hold(K_W, 20);
    while (m_cnt < 1798) frame(K_NONE);
    frame(K_SPACE);                         // hit beats timeout
    while (m_cnt < 1798) frame(K_NONE);
    hold(K_NONE, 3);                        // timeout, counter holds
    frame(K_ENTER); frame(K_NONE); frame(K_ENTER);
    hold(K_A, 106); hold(K_W, 20); frame(K_SPACE);
    hold(K_D, 65);                          // level 2 at X=450
    async_reset();

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 8))
        0: k = K_NONE;
        1: k = K_W;
        2: k = K_S;
        3: k = K_A;
        4: k = K_D;
        5: k = K_ENTER;
        6: k = K_SPACE;
        default: k = 8'($urandom);
      endcase
      len = int'($urandom_range(1, 12));
      if (k == K_ENTER || k == K_SPACE) begin
        frame(k);
        frame(K_NONE);
      end else begin
        hold(k, len);
      end
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge Clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d snapshots never compared, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pick_game_ctrl.md
Name: pick_game_ctrl

Overview:
Game controller that sits directly upstream of the colour mapper. It turns keyboard keycodes and the VGA frame strobe into the pick position (PickX, PickY) and the current screen code (currScreen) that the colour mapper consumes. It holds the screen state machine (title, two levels, win, fail), moves and clamps the pick once per frame, and judges pick attempts against a per-level target, with a retry count and a timeout.

Parameters:
X_MIN, 0, left pick bound
X_MAX, 639, right pick bound
Y_MIN, 0, top pick bound
Y_MAX, 479, bottom pick bound
STEP, 2, pixels moved per frame while a direction key is held
X_START, 320, pick X after reset and on every level entry
Y_START, 240, pick Y after reset and on every level entry
L1_TX, 100, level-1 target centre X
L1_TY, 200, level-1 target centre Y
L2_TX, 500, level-2 target centre X
L2_TY, 120, level-2 target centre Y
TGT_HALF, 8, target half-width; hit when |PickX-TX|<=TGT_HALF and |PickY-TY|<=TGT_HALF
MAX_TRIES, 3, attempts per level (1..7)
LEVEL_FRAMES, 1800, frames allowed per level (30 s at 60 Hz)

Ports:
Clk  input  1  system clock; the only clock
Reset  input  1  asynchronous, active-high reset
frame_clk  input  1  VGA vsync-rate signal, sampled as data on Clk
keycode  input  8  USB HID keycode, 0x00 = none
PickX  output  10  pick centre X, registered
PickY  output  10  pick centre Y, registered
currScreen  output  3  000 TITLE, 001 LEVEL1, 010 LEVEL2, 111 WIN, 100 FAIL
tries_left  output  3  remaining attempts in the current level
frame_cnt  output  11  frames elapsed in the current level

Behaviour:
- Reset (async, active-high) forces: currScreen=000, PickX=X_START, PickY=Y_START, tries_left=MAX_TRIES, frame_cnt=0, all edge-detect history cleared.
- Frame tick:
  - frame_clk is registered twice on Clk.
  - tick is a one-Clk pulse equal to (stage1 & ~stage2).
  - All state, position and counter updates occur only on Clk edges where tick=1. Outputs hold their values between ticks.
- Key sampling:
  - On each tick, keycode is latched into key_prev.
  - A press of K is defined as keycode==K on this tick and key_prev!=K.
  - Keys: W=0x1A (up), S=0x16 (down), A=0x04 (left), D=0x07 (right), ENTER=0x28, SPACE=0x2C.
- Movement:
  - Active only in LEVEL1 and LEVEL2, and applies while the key is held (level, not press).
  - A subtracts STEP from X; D adds STEP to X; W subtracts STEP from Y; S adds STEP to Y.
  - Compute in 11-bit signed arithmetic, then clamp to [MIN, MAX]. For example, X=1 with A pressed gives X_MIN; X=638 with D pressed gives 639.
  - Only one key can be active at a time, so diagonal movement is impossible.
  - In TITLE, WIN and FAIL the pick is held at X_START/Y_START.
- State machine (transitions evaluated on tick):
  - TITLE: ENTER press goes to LEVEL1 and reloads the level (pick to start, tries_left=MAX_TRIES, frame_cnt=0).
  - LEVEL1/LEVEL2, each tick: frame_cnt increments.
  - LEVEL1/LEVEL2, SPACE press, hit test uses the pick position before this tick's movement:
    - Hit: LEVEL1 goes to LEVEL2 with a level reload; LEVEL2 goes to WIN.
    - Miss: tries_left decrements. If it reaches 0, go to FAIL.
  - LEVEL1/LEVEL2, timeout: when frame_cnt==LEVEL_FRAMES-1 and no hit on this tick, go to FAIL.
  - LEVEL1/LEVEL2, simultaneous events on the same tick: a hit beats both timeout and a miss; a miss reaching 0 and a timeout both give FAIL.
  - WIN/FAIL: ENTER press goes to TITLE (pick to start, tries_left=MAX_TRIES, frame_cnt=0).
  - Any other currScreen encoding is illegal and recovers to TITLE on the next tick.
- Counter width rules:
  - frame_cnt saturates at LEVEL_FRAMES-1 and never wraps.
  - tries_left never underflows below 0.
- ENTER held across the TITLE-to-LEVEL1 transition does not re-trigger, because press is edge-based.
- Reset mid-level returns immediately (asynchronously) to the reset values.

Test Plan:
- Reset: assert Reset mid-LEVEL2 at PickX=450 -> outputs become 000/320/240/3/0 with no Clk edge required.
- Title to level 1: ENTER held for 3 ticks from TITLE -> currScreen=001 after the first tick only; tries_left=3, frame_cnt counts 1, 2.
- Clamp: LEVEL1, PickX=3, A held for 3 ticks -> PickX = 1, 0, 0. Then D held from PickX=637 -> 639, 639.
- Hit and miss: LEVEL1, pick at (108,200), SPACE press -> 010 and pick returns to (320,240). Pick at (109,200), SPACE pressed 3 times with releases in between -> tries 2, 1, then currScreen=100.
- Timeout tie: LEVEL1 with frame_cnt=1798 and a SPACE hit on the same tick -> 010, not 100. Without the hit -> 100 and frame_cnt holds at 1799.
- Frame gating: frame_clk held low with keys held -> no output changes for 1000 Clk cycles. After WIN, ENTER press -> 000.
